// File: rtl/fp_mul_sequencer.sv
// Sequential floating-point multiplier: shift-add mantissa multiply, normalize, pack.
// Define FP_MUL_ROUND_EN for round-to-nearest-even in NORM; otherwise the result is truncated.
module fp_mul_sequencer #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                                  clock_in,
  input  logic                                  reset_in,
  input  logic                                  start_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]     a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]     b_in,
  output logic                                  ready_out,
  output logic                                  done_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]     result_out,
  output logic                                  overflow_out,
  output logic                                  underflow_out,
  output logic                                  zero_out
);
  localparam int M  = MANTISSA_WIDTH;
  localparam int W  = 1 + EXP_WIDTH + M;
  localparam int PW = 2 * (M + 1);
  localparam int XW = EXP_WIDTH + 2;
  localparam int CW = $clog2(M + 2);
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;
  state_t state, state_nx;

  logic                 sign_q, zero_op_q;
  logic signed [XW-1:0] exp_q;
  logic [M:0]           ma_q, mb_q;
  logic [PW-1:0]        acc_q;
  logic [CW-1:0]        cnt_q;

  logic accept, a_zero, b_zero;
  assign ready_out = (state == IDLE) && !done_out;
  assign accept    = start_in && ready_out;
  assign a_zero    = (a_in[W-2 -: EXP_WIDTH] == '0);
  assign b_zero    = (b_in[W-2 -: EXP_WIDTH] == '0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (a_zero || b_zero) ? DONE : MULT;
      MULT:    if (cnt_q == CW'(M)) state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Normalization: product lies in [1,4); a set MSB means one extra exponent step.
  logic                 p_msb;
  logic [M-1:0]         frac_t, frac_f;
  logic signed [XW-1:0] exp_n, exp_f;
  assign p_msb  = acc_q[PW-1];
  assign frac_t = p_msb ? acc_q[2*M -: M] : acc_q[2*M-1 -: M];
  assign exp_n  = exp_q + (p_msb ? XW'(1) : XW'(0));

`ifdef FP_MUL_ROUND_EN
  logic guard, sticky, inc;
  logic [M:0] frac_r;
  always_comb begin
    guard  = p_msb ? acc_q[M] : acc_q[M-1];
    sticky = p_msb ? |acc_q[M-1:0] : |acc_q[M-2:0];
    inc    = guard & (sticky | frac_t[0]);
    frac_r = {1'b0, frac_t} + {{M{1'b0}}, inc};
    frac_f = frac_r[M-1:0];
    exp_f  = exp_n + (frac_r[M] ? XW'(1) : XW'(0));
  end
`else
  assign frac_f = frac_t;
  assign exp_f  = exp_n;
`endif

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state         <= IDLE;
      done_out      <= 1'b0;
      result_out    <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
      zero_out      <= 1'b0;
      sign_q        <= 1'b0;
      zero_op_q     <= 1'b0;
      exp_q         <= '0;
      ma_q          <= '0;
      mb_q          <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
    end else begin
      state    <= state_nx;
      done_out <= (state == DONE);
      case (state)
        IDLE: if (accept) begin
          sign_q        <= a_in[W-1] ^ b_in[W-1];
          zero_op_q     <= a_zero || b_zero;
          exp_q         <= $signed({2'b00, a_in[W-2 -: EXP_WIDTH]})
                         + $signed({2'b00, b_in[W-2 -: EXP_WIDTH]}) - BIAS;
          ma_q          <= {1'b1, a_in[M-1:0]};
          mb_q          <= {1'b1, b_in[M-1:0]};
          acc_q         <= '0;
          cnt_q         <= '0;
          result_out    <= '0;
          overflow_out  <= 1'b0;
          underflow_out <= 1'b0;
          zero_out      <= 1'b0;
        end
        MULT: begin
          if (mb_q[cnt_q]) acc_q <= acc_q + (PW'(ma_q) << cnt_q);
          cnt_q <= cnt_q + CW'(1);
        end
        NORM: begin
          if (exp_f >= EXP_MAX) begin
            result_out   <= {sign_q, {EXP_WIDTH{1'b1}}, {M{1'b0}}};
            overflow_out <= 1'b1;
          end else if (exp_f <= 0) begin
            result_out    <= {sign_q, {(W-1){1'b0}}};
            underflow_out <= 1'b1;
            zero_out      <= 1'b1;
          end else begin
            result_out <= {sign_q, exp_f[EXP_WIDTH-1:0], frac_f};
          end
        end
        DONE: if (zero_op_q) begin
          result_out <= {sign_q, {(W-1){1'b0}}};
          zero_out   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Directed bench for fp_mul_sequencer: results, flags, latency, handshake and reset.
module tb_fp_mul_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        ready, done, ovf, unf, zero;
  logic [31:0] result;
  int          n_chk = 0, n_fail = 0;

  fp_mul_sequencer dut (
    .clock_in(clk), .reset_in(rst), .start_in(start), .a_in(a), .b_in(b),
    .ready_out(ready), .done_out(done), .result_out(result),
    .overflow_out(ovf), .underflow_out(unf), .zero_out(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op, optionally pulse a stray start at cycle pulse_at, then check outcome.
  task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                     input int pulse_at, input logic [31:0] exp_res,
                     input logic [2:0] exp_flg, input int exp_lat);
    int w = 0, lat = 0, rdy_bad = 0;
    @(negedge clk);
    while (!ready && w < 100) begin @(negedge clk); w++; end
    chk({tag, "_ready"}, ready, 1);
    a = ta; b = tb_; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_clr"}, {ready, done, ovf, unf, zero, result}, 0);
    while (!done && lat < 100) begin
      if (lat == pulse_at) begin a = 32'h40000000; b = 32'h40000000; start = 1'b1; end
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (!done && ready) rdy_bad++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdylow"}, rdy_bad, 0);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_flags"}, {ovf, unf, zero}, exp_flg);
  endtask

  initial begin
    int spurious = 0;
    // start coincident with reset must be discarded
    a = 32'h3F800000; b = 32'h3F800000; start = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("reset_state", {ready, done, ovf, unf, zero, result}, {1'b1, 36'h0});

    run("basic",   32'h3FC00000, 32'h40000000, -1, 32'h40400000, 3'b000, 26);
    run("negzero", 32'h80000000, 32'h3F800000, -1, 32'h80000000, 3'b001, 1);
    run("poszero", 32'h00000000, 32'h40490FDB, -1, 32'h00000000, 3'b001, 1);
    run("neg",     32'hC0000000, 32'h40400000, -1, 32'hC0C00000, 3'b000, 26);
    run("ovf",     32'h7F000000, 32'h7F000000, -1, 32'h7F800000, 3'b100, 26);
    run("unf_b2b", 32'h00800000, 32'h00800000, -1, 32'h00000000, 3'b011, 26);
`ifdef FP_MUL_ROUND_EN
    run("round",   32'h3FC00001, 32'h3FC00001, -1, 32'h40100002, 3'b000, 26);
`else
    run("round",   32'h3FC00001, 32'h3FC00001, -1, 32'h40100001, 3'b000, 26);
`endif
    run("ignore",  32'h3F800000, 32'h40400000, 5, 32'h40400000, 3'b000, 26);

    // reset in the middle of MULT
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", {ready, done, result}, {1'b1, 33'h0});
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) spurious++;
    end
    chk("midrst_nodone", spurious, 0);
    run("after_rst", 32'h3F800000, 32'h3F800000, -1, 32'h3F800000, 3'b000, 26);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
